phase_sequencer: RTL and testbench

- Parametrised round-robin phase sequencer; successor to the fixed three-state input/action/display controller.
- Drives a one-hot enable to each of `NUM_PHASES` sub-blocks and advances on that sub-block's done strobe.
- Adds single-shot and free-running modes, a frame counter, clock-enable freeze, and an optional per-phase watchdog timeout.
- Sits at the top of a game/display design between the pad-facing top level and the input, action and display engines.

---
 rtl/phase_sequencer.sv | 166 ++++++++++++++++
 tb/tb_phase_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// Round-robin phase sequencer: one-hot enable per phase, advance on that phase's done, optional watchdog (PHASE_TIMEOUT_EN).
// Latency: 1 cycle start and handoff; ena low freezes all state (no backpressure otherwise).
module phase_sequencer #(
  parameter int NUM_PHASES = 3,
  parameter int PH_W       = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1,
  parameter int FRAME_W    = 8,
  parameter int TIMEOUT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  run_i,
  input  logic                  mode_i,
  input  logic [NUM_PHASES-1:0] done_i,
  input  logic [TIMEOUT_W-1:0]  timeout_lim_i,
  output logic [NUM_PHASES-1:0] en_o,
  output logic [PH_W-1:0]       phase_o,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic [FRAME_W-1:0]    frame_cnt_o,
  output logic                  timeout_o,
  output logic [PH_W-1:0]       timeout_phase_o
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [PH_W-1:0]      phase_q, phase_d;
  logic                 mode_q, mode_d;
  logic [FRAME_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic                 frame_done_q, frame_done_d;

  logic                 done_act;
  logic                 expire;
  logic                 complete;
  logic                 last_phase;
  logic [NUM_PHASES-1:0] one_hot;

  // Only the active phase's done bit is ever looked at.
  assign done_act   = done_i[phase_q];
  assign last_phase = (phase_q == PH_W'(NUM_PHASES - 1));
  assign complete   = (state_q == S_RUN) && (done_act || expire);
  assign one_hot    = {{(NUM_PHASES-1){1'b0}}, 1'b1} << phase_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      phase_q      <= '0;
      mode_q       <= 1'b0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      mode_q       <= mode_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    mode_d       = mode_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = frame_done_q;
    if (ena) begin
      frame_done_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (run_i) begin
            state_d = S_RUN;
            mode_d  = mode_i;
            phase_d = '0;
          end
        end
        S_RUN: begin
          if (complete) begin
            if (!last_phase) begin
              phase_d = phase_q + PH_W'(1);
            end else begin
              phase_d      = '0;
              frame_cnt_d  = frame_cnt_q + FRAME_W'(1);
              frame_done_d = 1'b1;
              // Free-running continues only if run_i is still asserted at frame wrap.
              if (!(mode_q && run_i)) begin
                state_d = S_IDLE;
              end
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          phase_d = '0;
        end
      endcase
    end
  end

`ifdef PHASE_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic                 timeout_q, timeout_d;
  logic [PH_W-1:0]      tphase_q, tphase_d;

  // Done in the expiry cycle takes precedence, so expiry requires done low.
  assign expire = (timeout_lim_i != '0) &&
                  (wd_cnt_q == timeout_lim_i - TIMEOUT_W'(1)) && !done_act;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
      tphase_q  <= '0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
      tphase_q  <= tphase_d;
    end
  end

  always_comb begin
    wd_cnt_d  = wd_cnt_q;
    timeout_d = timeout_q;
    tphase_d  = tphase_q;
    if (ena) begin
      if (state_q == S_IDLE) begin
        if (run_i) begin
          wd_cnt_d  = '0;
          timeout_d = 1'b0;
          tphase_d  = '0;
        end
      end else begin
        if (complete) begin
          wd_cnt_d = '0;
        end else if (wd_cnt_q != {TIMEOUT_W{1'b1}}) begin
          wd_cnt_d = wd_cnt_q + TIMEOUT_W'(1);
        end
        if (expire) begin
          timeout_d = 1'b1;
          tphase_d  = phase_q;
        end
      end
    end
  end

  assign timeout_o       = timeout_q;
  assign timeout_phase_o = tphase_q;
`else
  logic unused_lim;

  assign unused_lim      = ^timeout_lim_i;
  assign expire          = 1'b0;
  assign timeout_o       = 1'b0;
  assign timeout_phase_o = '0;
`endif

  assign en_o         = (state_q == S_RUN) ? one_hot : '0;
  assign phase_o      = phase_q;
  assign busy_o       = (state_q == S_RUN);
  assign frame_done_o = frame_done_q;
  assign frame_cnt_o  = frame_cnt_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed table-driven bench for phase_sequencer (3 phases, 2-bit frame counter).
module tb_phase_sequencer;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic        run_i;
  logic        mode_i;
  logic [2:0]  done_i;
  logic [15:0] timeout_lim_i;
  logic [2:0]  en_o;
  logic [1:0]  phase_o;
  logic        busy_o;
  logic        frame_done_o;
  logic [1:0]  frame_cnt_o;
  logic        timeout_o;
  logic [1:0]  timeout_phase_o;

  int checks;
  int failures;

  phase_sequencer #(
    .NUM_PHASES(3),
    .FRAME_W   (2),
    .TIMEOUT_W (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ena            (ena),
    .run_i          (run_i),
    .mode_i         (mode_i),
    .done_i         (done_i),
    .timeout_lim_i  (timeout_lim_i),
    .en_o           (en_o),
    .phase_o        (phase_o),
    .busy_o         (busy_o),
    .frame_done_o   (frame_done_o),
    .frame_cnt_o    (frame_cnt_o),
    .timeout_o      (timeout_o),
    .timeout_phase_o(timeout_phase_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       run;
    logic       mode;
    logic       ena;
    logic [2:0] done;
    logic [2:0] en;
    logic [1:0] ph;
    logic       busy;
    logic       fd;
    logic [1:0] cnt;
  } vec_t;

  vec_t vq[$];

  task automatic addv(input logic r, input logic m, input logic e, input logic [2:0] d,
                      input logic [2:0] en, input logic [1:0] ph, input logic b,
                      input logic fd, input logic [1:0] cnt);
    vec_t v;
    v.run = r; v.mode = m; v.ena = e; v.done = d;
    v.en = en; v.ph = ph; v.busy = b; v.fd = fd; v.cnt = cnt;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string nm, input logic [2:0] en, input logic [1:0] ph,
                           input logic b, input logic fd, input logic [1:0] cnt);
    chk({nm, ".en"}, 32'(en_o), 32'(en));
    chk({nm, ".phase"}, 32'(phase_o), 32'(ph));
    chk({nm, ".busy"}, 32'(busy_o), 32'(b));
    chk({nm, ".frame_done"}, 32'(frame_done_o), 32'(fd));
    chk({nm, ".frame_cnt"}, 32'(frame_cnt_o), 32'(cnt));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    ena = 1'b1;
    run_i = 1'b0;
    mode_i = 1'b0;
    done_i = 3'b000;
    timeout_lim_i = 16'd0;

    #2;
    chk_state("reset", 3'b000, 2'd0, 1'b0, 1'b0, 2'd0);
    chk("reset.timeout", 32'(timeout_o), 32'd0);
    chk("reset.timeout_phase", 32'(timeout_phase_o), 32'd0);
    tick();
    rst_n = 1'b1;

    // Single-shot frame, done on 2nd enabled cycle of each phase
    addv(1, 0, 1, 3'b000, 3'b001, 2'd0, 1, 0, 2'd0);
    addv(0, 0, 1, 3'b000, 3'b001, 2'd0, 1, 0, 2'd0);
    addv(0, 0, 1, 3'b001, 3'b010, 2'd1, 1, 0, 2'd0);
    addv(0, 0, 1, 3'b000, 3'b010, 2'd1, 1, 0, 2'd0);
    addv(0, 0, 1, 3'b010, 3'b100, 2'd2, 1, 0, 2'd0);
    addv(0, 0, 1, 3'b000, 3'b100, 2'd2, 1, 0, 2'd0);
    addv(0, 0, 1, 3'b100, 3'b000, 2'd0, 0, 1, 2'd1);
    addv(0, 0, 1, 3'b000, 3'b000, 2'd0, 0, 0, 2'd1);
    addv(0, 0, 1, 3'b111, 3'b000, 2'd0, 0, 0, 2'd1);
    // Stray done bits, then freeze with the active done high
    addv(1, 0, 1, 3'b000, 3'b001, 2'd0, 1, 0, 2'd1);
    addv(0, 0, 1, 3'b110, 3'b001, 2'd0, 1, 0, 2'd1);
    for (int k = 0; k < 10; k++) addv(0, 0, 0, 3'b001, 3'b001, 2'd0, 1, 0, 2'd1);
    addv(0, 0, 1, 3'b001, 3'b010, 2'd1, 1, 0, 2'd1);
    addv(0, 0, 1, 3'b010, 3'b100, 2'd2, 1, 0, 2'd1);
    addv(0, 0, 1, 3'b100, 3'b000, 2'd0, 0, 1, 2'd2);
    // frame_done pulse held while frozen; run ignored while frozen
    addv(0, 0, 0, 3'b000, 3'b000, 2'd0, 0, 1, 2'd2);
    addv(1, 0, 0, 3'b000, 3'b000, 2'd0, 0, 1, 2'd2);
    addv(0, 0, 1, 3'b000, 3'b000, 2'd0, 0, 0, 2'd2);

    foreach (vq[i]) begin
      run_i  = vq[i].run;
      mode_i = vq[i].mode;
      ena    = vq[i].ena;
      done_i = vq[i].done;
      tick();
      chk_state($sformatf("vec%0d", i), vq[i].en, vq[i].ph, vq[i].busy, vq[i].fd, vq[i].cnt);
    end
    ena = 1'b1; run_i = 1'b0; done_i = 3'b000;

    // Free-running, five frames then drop run mid frame 6
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    mode_i = 1'b1; run_i = 1'b1; done_i = 3'b111;
    tick();
    chk_state("fr.start", 3'b001, 2'd0, 1'b1, 1'b0, 2'd0);
    for (int f = 1; f <= 5; f++) begin
      tick();
      chk(($sformatf("fr%0d.p1", f)), 32'(en_o), 32'b010);
      tick();
      chk(($sformatf("fr%0d.p2", f)), 32'(en_o), 32'b100);
      tick();
      chk_state($sformatf("fr%0d.end", f), 3'b001, 2'd0, 1'b1, 1'b1, 2'(f % 4));
    end
    tick();
    chk("fr6.p1", 32'(en_o), 32'b010);
    run_i = 1'b0;
    tick();
    chk("fr6.p2", 32'(en_o), 32'b100);
    tick();
    chk_state("fr6.end", 3'b000, 2'd0, 1'b0, 1'b1, 2'd2);
    tick();
    chk_state("fr6.idle", 3'b000, 2'd0, 1'b0, 1'b0, 2'd2);
    done_i = 3'b000; mode_i = 1'b0;

    // Asynchronous reset in the middle of phase 1
    run_i = 1'b1;
    tick();
    run_i = 1'b0; done_i = 3'b001;
    tick();
    chk("arst.pre", 32'(en_o), 32'b010);
    done_i = 3'b000;
    #2;
    rst_n = 1'b0;
    #1;
    chk_state("arst", 3'b000, 2'd0, 1'b0, 1'b0, 2'd2 - 2'd2);
    #1;
    rst_n = 1'b1;
    tick();

`ifdef PHASE_TIMEOUT_EN
    timeout_lim_i = 16'd4;
    run_i = 1'b1;
    tick();
    run_i = 1'b0; done_i = 3'b001;
    tick();
    chk("wd.p1", 32'(en_o), 32'b010);
    done_i = 3'b000;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("wd.hold%0d", k), 32'(en_o), 32'b010);
      chk($sformatf("wd.to%0d", k), 32'(timeout_o), 32'd0);
    end
    tick();
    chk("wd.exp.en", 32'(en_o), 32'b100);
    chk("wd.exp.flag", 32'(timeout_o), 32'd1);
    chk("wd.exp.phase", 32'(timeout_phase_o), 32'd1);
    done_i = 3'b100;
    tick();
    chk("wd.idle.busy", 32'(busy_o), 32'd0);
    chk("wd.idle.flag", 32'(timeout_o), 32'd1);
    done_i = 3'b000; run_i = 1'b1;
    tick();
    chk("wd.restart.flag", 32'(timeout_o), 32'd0);
    chk("wd.restart.en", 32'(en_o), 32'b001);
    run_i = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("wd.race.pre", 32'(en_o), 32'b001);
    done_i = 3'b001;
    tick();
    chk("wd.race.en", 32'(en_o), 32'b010);
    chk("wd.race.flag", 32'(timeout_o), 32'd0);
    done_i = 3'b111;
    tick();
    tick();
    chk("wd.race.end", 32'(busy_o), 32'd0);
    chk("wd.race.flag2", 32'(timeout_o), 32'd0);
`else
    timeout_lim_i = 16'd4;
    run_i = 1'b1;
    tick();
    run_i = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("nowd.en", 32'(en_o), 32'b001);
    chk("nowd.flag", 32'(timeout_o), 32'd0);
    done_i = 3'b111;
    for (int k = 0; k < 3; k++) tick();
    chk("nowd.end", 32'(busy_o), 32'd0);
`endif
    done_i = 3'b000;
    timeout_lim_i = 16'd0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
